// File: rtl/demux_word_sched.sv
// Round-robin word scheduler feeding a shared 32->8 byte demux.
// Each granted word is presented for exactly four clk_4f cycles (beat 0..3)
// so the demux always starts a word at byte [31:24]; back-to-back words
// follow with no bubble. Optional feature macro: DEMUX_SCHED_IDLE_FILL_EN
// (when defined, idle words 32'hBCBCBCBC keep the demux busy while nothing
// is granted, and new grants are taken only on a word boundary).
module demux_word_sched #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 2
) (
  input  logic                   clk_4f,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*32-1:0]  data_in,
  output logic [NUM_REQ-1:0]     ack,
  output logic [31:0]            mux_data,
  output logic                   mux_valid,
  output logic [PTR_W-1:0]       mux_lane,
  output logic [1:0]             beat,
  output logic                   busy
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

`ifdef DEMUX_SCHED_IDLE_FILL_EN
  localparam logic [31:0] IdleWord = 32'hBCBCBCBC;
`endif

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [31:0]          mux_data_q, mux_data_d;
  logic                 mux_valid_q, mux_valid_d;
  logic [PTR_W-1:0]     mux_lane_q, mux_lane_d;
  logic [1:0]           beat_q, beat_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]   win_oh;
  logic [31:0]          win_data;
  logic                 word_end;
  logic                 grant_ok;

  // Round-robin pick: first requester above last_grant, then wrap from lane 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!win_found && req[i] && (i > int'(last_grant_q))) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_data  = data_in[32*i +: 32];
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_data  = data_in[32*i +: 32];
      end
    end
  end

  // Word boundary detection; grants are only taken where a new word may start.
  always_comb begin
`ifdef DEMUX_SCHED_IDLE_FILL_EN
    // Right after reset nothing is on the demux yet, so start an idle word first.
    word_end = !mux_valid_q || (beat_q == 2'd3);
    grant_ok = mux_valid_q && (beat_q == 2'd3);
`else
    word_end = (state_q == StIdle) || (beat_q == 2'd3);
    grant_ok = word_end;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ack_d        = '0;
    mux_data_d   = mux_data_q;
    mux_valid_d  = mux_valid_q;
    mux_lane_d   = mux_lane_q;
    beat_d       = beat_q;
    busy_d       = busy_q;
    if (!word_end) begin
      beat_d = beat_q + 2'd1;
    end else if (grant_ok && win_found) begin
      state_d      = StSend;
      last_grant_d = win_idx;
      ack_d        = win_oh;
      mux_data_d   = win_data;
      mux_valid_d  = 1'b1;
      mux_lane_d   = win_idx;
      beat_d       = 2'd0;
      busy_d       = 1'b1;
    end else begin
      state_d    = StIdle;
      beat_d     = 2'd0;
      busy_d     = 1'b0;
      mux_lane_d = '0;
`ifdef DEMUX_SCHED_IDLE_FILL_EN
      mux_valid_d = 1'b1;
      mux_data_d  = IdleWord;
`else
      mux_valid_d = 1'b0;
`endif
    end
  end

  // State and output registers; reset drops any partially sent word.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= PTR_W'(NUM_REQ - 1);
      ack_q        <= '0;
      mux_data_q   <= '0;
      mux_valid_q  <= 1'b0;
      mux_lane_q   <= '0;
      beat_q       <= 2'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      mux_data_q   <= mux_data_d;
      mux_valid_q  <= mux_valid_d;
      mux_lane_q   <= mux_lane_d;
      beat_q       <= beat_d;
      busy_q       <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign mux_data  = mux_data_q;
  assign mux_valid = mux_valid_q;
  assign mux_lane  = mux_lane_q;
  assign beat      = beat_q;
  assign busy      = busy_q;

endmodule
